b200_io_mode_ctrl: RTL and testbench
====================================

Name: b200_io_mode_ctrl

Overview:
- Bus-clock-domain sequencer that owns the SISO/MIMO mode select feeding the AD9361 source-synchronous I/O block.
- Changing mode switches the radio_clk global mux, which glitches radio_clk. This block therefore:
  - quiesces the radio cores;
  - flips the mode;
  - waits for the mux and synchronizers to settle;
  - proves radio_clk is alive again via a heartbeat;
  - then releases the radios.
- Reports busy, done and error to the settings/readback logic.

Parameters:
- SETTLE_CYCLES, 256, clk cycles to wait after driving mimo before heartbeat checking starts (must be >= 2).
- HB_EDGES, 8, synchronized heartbeat transitions required to declare radio_clk alive.
- QUIESCE_TIMEOUT, 4096, max clk cycles waiting for radio_idle.
- HB_TIMEOUT, 65535, max clk cycles waiting for HB_EDGES transitions.

Ports:
- clk  in  1  bus clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- mode_req_stb  in  1  one-cycle request strobe.
- mode_req_mimo  in  1  requested mode (1 = MIMO, 0 = SISO), valid with mode_req_stb.
- radio_idle  in  1  radio cores are quiescent; already synchronized to clk.
- radio_hb  in  1  toggles once per radio_clk/2 (or slower), asynchronous to clk.
- mimo  out  1  mode select driven to the I/O block.
- radio_hold  out  1  holds radio cores in quiesce/reset.
- busy  out  1  high in any state other than IDLE and ERR.
- done_stb  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky failure flag.
- err_code  out  2  0 = none, 1 = quiesce timeout, 2 = heartbeat timeout.
- req_dropped  out  1  one-cycle pulse when a request arrives while busy.

Behaviour:
- Reset values: mimo=0, radio_hold=0, busy=0, done_stb=0, error=0, err_code=0, req_dropped=0; state=IDLE; counters=0; heartbeat synchronizer flops=0.
- Heartbeat sync:
  - 2-flop synchronizer plus a third edge-detect flop.
  - hb_edge = sync2 ^ sync3.
  - Synchronizer runs in every state.
- Single down/up counter, width clog2(max(SETTLE_CYCLES, QUIESCE_TIMEOUT, HB_TIMEOUT)+1).
- Separate edge counter, width clog2(HB_EDGES+1).
- IDLE:
  - mode_req_stb with mode_req_mimo==mimo: done_stb=1 on the next cycle; no hold, no mode change.
  - Otherwise latch target=mode_req_mimo, go to QUIESCE; radio_hold=1 from the next cycle.
- QUIESCE (radio_hold=1, counter counts up):
  - radio_idle=1 -> SWITCH.
  - Counter reaches QUIESCE_TIMEOUT with radio_idle still 0 -> ERR, err_code=1.
  - radio_idle wins if it rises in the same cycle the timeout is reached.
- SWITCH (one cycle): mimo<=target; clear counter -> SETTLE.
- SETTLE: count SETTLE_CYCLES cycles -> HBCHECK.
- HBCHECK:
  - Clear the edge counter on entry.
  - Count hb_edge events.
  - HB_EDGES edges -> RELEASE.
  - HB_TIMEOUT cycles elapsed first -> ERR, err_code=2.
  - Success wins if both happen in the same cycle.
- RELEASE (one cycle): radio_hold<=0, done_stb=1 -> IDLE.
- ERR:
  - error=1, radio_hold stays 1, mimo keeps the value already driven, busy=0.
  - A new mode_req_stb clears error and err_code and restarts at QUIESCE.
  - The same-mode shortcut does not apply in ERR; a full sequence always runs.
- Request while busy: ignored; req_dropped pulses the following cycle; target unchanged.
- reset mid-sequence: everything returns to reset values. mimo drops to 0 immediately, so the SISO mode is re-entered.
- Minimum successful latency, request to done_stb, assuming radio_idle already high: 1 (QUIESCE) + 1 (SWITCH) + SETTLE_CYCLES + HBCHECK time + 1 (RELEASE).

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, QUIESCE, SWITCH, SETTLE, HBCHECK, RELEASE, ERR;
  - err_code constants: ERR_NONE, ERR_QUIESCE, ERR_HB.
- One sub-module: b200_hb_sync (3-flop synchronizer plus edge detect), reusable by other bus-side clock monitors.

Test Plan:
- SISO->MIMO, SETTLE_CYCLES=16, HB_EDGES=4, radio_idle already 1, radio_hb toggling every 3 clk -> radio_hold rises 1 cycle after the strobe, mimo=1 at SWITCH+1, single done_stb, radio_hold=0, error=0.
- Same-mode request: mimo=0, req mimo=0 -> done_stb exactly 1 cycle later, radio_hold never asserts.
- radio_idle held 0, QUIESCE_TIMEOUT=32 -> error=1, err_code=1 after 32 cycles, mimo unchanged at 0, radio_hold=1; a later request with radio_idle=1 completes and clears error.
- radio_hb frozen after SWITCH, HB_TIMEOUT=100 -> err_code=2, mimo=1, radio_hold=1, busy=0.
- Second strobe during SETTLE -> req_dropped pulse, sequence completes with the original target, one done_stb.
- reset asserted during HBCHECK with mimo=1 -> next cycle mimo=0, radio_hold=0, busy=0, error=0.

Source files
------------

// File: rtl/b200_io_mode_ctrl_pkg.sv
// Shared definitions for the SISO/MIMO mode-switch sequencer: FSM state
// encoding, error codes and a small sizing helper.
package b200_io_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    SWITCH  = 3'd2,
    SETTLE  = 3'd3,
    HBCHECK = 3'd4,
    RELEASE = 3'd5,
    ERR     = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_QUIESCE = 2'd1;
  localparam logic [1:0] ERR_HB      = 2'd2;

  // Largest of three values; used to size the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/b200_hb_sync.sv
// Brings an asynchronous heartbeat into the clk domain with a 2-flop
// synchronizer and flags every transition with a third edge-detect flop.
module b200_hb_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic edge_out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;

  // Shift the raw heartbeat through the synchronizer chain.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  // Synchronizer and edge-detect registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  assign sync_out = sync2_q;
  assign edge_out = sync2_q ^ sync3_q;

endmodule

// File: rtl/b200_io_mode_ctrl.sv
// Sequencer owning the AD9361 SISO/MIMO select. A mode change quiesces the
// radios, flips mimo, waits for the radio_clk mux to settle, proves
// radio_clk is alive through the heartbeat, then releases the radios.
//
// Request handshake: mode_req_stb is a one-cycle strobe with mode_req_mimo
// valid alongside it; there is no ready. A strobe taken in IDLE or ERR is
// accepted; a strobe while busy is discarded and answered by a one-cycle
// req_dropped pulse on the following cycle.
module b200_io_mode_ctrl
  import b200_io_mode_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES   = 256,
  parameter int HB_EDGES        = 8,
  parameter int QUIESCE_TIMEOUT = 4096,
  parameter int HB_TIMEOUT      = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_req_stb,
  input  logic       mode_req_mimo,
  input  logic       radio_idle,
  input  logic       radio_hb,
  output logic       mimo,
  output logic       radio_hold,
  output logic       busy,
  output logic       done_stb,
  output logic       error,
  output logic [1:0] err_code,
  output logic       req_dropped
);

  localparam int CNT_W  = $clog2(max3(SETTLE_CYCLES, QUIESCE_TIMEOUT, HB_TIMEOUT) + 1);
  localparam int EDGE_W = $clog2(HB_EDGES + 1);

  localparam logic [CNT_W-1:0]  Q_LAST   = CNT_W'(QUIESCE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  S_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(HB_TIMEOUT - 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(HB_EDGES);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [EDGE_W-1:0]   edge_sum;
  logic                target_q, target_d;
  logic                mimo_q, mimo_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                drop_q, drop_d;
  logic                busy_w;
  logic                hb_sync;
  logic                hb_edge;

  b200_hb_sync u_hb_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (radio_hb),
    .sync_out (hb_sync),
    .edge_out (hb_edge)
  );

  // Idle and error are the only states that accept a new request.
  assign busy_w = (state_q != IDLE) && (state_q != ERR);

  // Next-state and output decode for the mode-switch sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    target_d   = target_q;
    mimo_d     = mimo_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    error_d    = error_q;
    err_code_d = err_code_q;
    drop_d     = mode_req_stb && busy_w;
    edge_sum   = edge_cnt_q + EDGE_W'(hb_edge);

    unique case (state_q)
      IDLE: begin
        if (mode_req_stb) begin
          if (mode_req_mimo == mimo_q) begin
            done_d = 1'b1;
          end else begin
            target_d = mode_req_mimo;
            hold_d   = 1'b1;
            cnt_d    = '0;
            state_d  = QUIESCE;
          end
        end
      end
      QUIESCE: begin
        // radio_idle is checked first so it wins over a coincident timeout.
        if (radio_idle) begin
          state_d = SWITCH;
        end else if (cnt_q == Q_LAST) begin
          state_d    = ERR;
          error_d    = 1'b1;
          err_code_d = ERR_QUIESCE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SWITCH: begin
        mimo_d  = target_q;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == S_LAST) begin
          cnt_d      = '0;
          edge_cnt_d = '0;
          state_d    = HBCHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HBCHECK: begin
        // Reaching the edge target wins over a coincident timeout.
        if (edge_sum == EDGE_MAX) begin
          state_d = RELEASE;
        end else if (cnt_q == H_LAST) begin
          state_d    = ERR;
          error_d    = 1'b1;
          err_code_d = ERR_HB;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          edge_cnt_d = edge_sum;
        end
      end
      RELEASE: begin
        hold_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        // Radios stay held; any request restarts a full sequence.
        if (mode_req_stb) begin
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          target_d   = mode_req_mimo;
          cnt_d      = '0;
          state_d    = QUIESCE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset returns to SISO, unheld.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      target_q   <= 1'b0;
      mimo_q     <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      target_q   <= target_d;
      mimo_q     <= mimo_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      drop_q     <= drop_d;
    end
  end

  assign mimo        = mimo_q;
  assign radio_hold  = hold_q;
  assign busy        = busy_w;
  assign done_stb    = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;
  assign req_dropped = drop_q;

endmodule

// File: tb/tb_b200_io_mode_ctrl.sv
// Bench for b200_io_mode_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic, all checked cycle by cycle against a
// timeline-based reference model.
module tb_b200_io_mode_ctrl;

  localparam int S   = 16;
  localparam int HBE = 4;
  localparam int QT  = 32;
  localparam int HBT = 100;
  localparam int W   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode_req_stb = 1'b0;
  logic mode_req_mimo = 1'b0;
  logic radio_idle = 1'b0;
  logic radio_hb = 1'b0;
  logic mimo, radio_hold, busy, done_stb, error, req_dropped;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  b200_io_mode_ctrl #(
    .SETTLE_CYCLES   (S),
    .HB_EDGES        (HBE),
    .QUIESCE_TIMEOUT (QT),
    .HB_TIMEOUT      (HBT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mode_req_stb  (mode_req_stb),
    .mode_req_mimo (mode_req_mimo),
    .radio_idle    (radio_idle),
    .radio_hb      (radio_hb),
    .mimo          (mimo),
    .radio_hold    (radio_hold),
    .busy          (busy),
    .done_stb      (done_stb),
    .error         (error),
    .err_code      (err_code),
    .req_dropped   (req_dropped)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {mimo, radio_hold, busy, done_stb, error, err_code, req_dropped};
  endfunction

  // ---------------- reference model ----------------
  // Tracks a request as a timeline of absolute edge numbers: the edge the
  // request was accepted, the edge mimo flips, and the edge done appears.
  longint n_edge = 0;
  longint t_acc, t_sw, t_rel;
  int     hb_seen;
  bit     seq_on = 0;
  bit     m_target = 0;
  bit     m_mimo = 0, m_hold = 0, m_err = 0, m_done = 0, m_drop = 0;
  bit [1:0] m_code = 0;
  bit     h1 = 0, h2 = 0, h3 = 0;

  task automatic model_step();
    bit hb_ev;
    hb_ev = h2 ^ h3;
    h3 = h2; h2 = h1; h1 = radio_hb;
    n_edge++;
    m_done = 0;
    m_drop = 0;
    if (reset) begin
      h1 = 0; h2 = 0; h3 = 0;
      seq_on = 0; m_target = 0;
      m_mimo = 0; m_hold = 0; m_err = 0; m_code = 0;
    end else if (!seq_on) begin
      if (mode_req_stb) begin
        if (!m_err && mode_req_mimo == m_mimo) begin
          m_done = 1;
        end else begin
          seq_on = 1; m_target = mode_req_mimo;
          t_acc = n_edge; t_sw = -1; t_rel = -1; hb_seen = 0;
          m_hold = 1; m_err = 0; m_code = 0;
        end
      end
    end else begin
      if (mode_req_stb) m_drop = 1;
      if (t_sw < 0) begin
        if (radio_idle) t_sw = n_edge + 1;
        else if (n_edge - t_acc >= QT) begin
          seq_on = 0; m_err = 1; m_code = 2'd1;
        end
      end else if (n_edge == t_sw) begin
        m_mimo = m_target;
      end else if (n_edge > t_sw + S) begin
        if (t_rel >= 0) begin
          m_hold = 0; m_done = 1; seq_on = 0;
        end else begin
          hb_seen += int'(hb_ev);
          if (hb_seen >= HBE) t_rel = n_edge + 1;
          else if (n_edge - (t_sw + S) >= HBT) begin
            seq_on = 0; m_err = 1; m_code = 2'd2;
          end
        end
      end
    end
    exp_q.push_back({m_mimo, m_hold, seq_on, m_done, m_err, m_code, m_drop});
  endtask

  // ---------------- driver ----------------
  int hb_period = 0;
  int hb_cnt    = 0;

  // One clk cycle: model at the rising edge, compare at the falling edge,
  // then advance the heartbeat generator.
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    check("cycle_outputs", 32'(dut_vec()), 32'(e));
    if (hb_period > 0) begin
      hb_cnt++;
      if (hb_cnt >= hb_period) begin
        hb_cnt = 0;
        radio_hb = ~radio_hb;
      end
    end
  endtask

  task automatic strobe(input logic req);
    mode_req_mimo = req;
    mode_req_stb  = 1'b1;
    step();
    mode_req_stb  = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       req;
    int         idle_delay;  // 0: already high, -1: never, k: rises k cycles after strobe
    int         hb_per;      // 0: heartbeat frozen
    logic [1:0] code;
    logic       exp_mimo;
    logic       exp_hold;
    logic       exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int done_cnt;
    int idle_pct;

    vecs[0] = '{1'b1,  0, 3, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, -1, 3, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0,  5, 3, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1,  0, 0, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1,  0, 4, 2'd0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0,  2, 2, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, -1, 3, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1,  0, 3, 2'd0, 1'b1, 1'b0, 1'b1};

    // Reset.
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset_values", 32'(dut_vec()), 32'h0);

    // Same-mode request: done one cycle later, no hold.
    strobe(1'b0);
    check("same_mode_done", done_stb, 1'b1);
    check("same_mode_hold", radio_hold, 1'b0);
    step();
    check("same_mode_done_single", done_stb, 1'b0);

    // Table-driven full sequences.
    for (int i = 0; i < 8; i++) begin
      hb_period  = vecs[i].hb_per;
      hb_cnt     = 0;
      radio_idle = (vecs[i].idle_delay == 0);
      strobe(vecs[i].req);
      check($sformatf("v%0d_hold_after_stb", i), radio_hold, 1'b1);
      n = 0;
      while (!done_stb && !error && n < 300) begin
        if (vecs[i].idle_delay > 0 && n + 1 >= vecs[i].idle_delay) radio_idle = 1'b1;
        step();
        n++;
      end
      check($sformatf("v%0d_finished", i), 32'(n < 300), 32'd1);
      check($sformatf("v%0d_err_code", i), err_code, vecs[i].code);
      check($sformatf("v%0d_error", i), error, (vecs[i].code != 2'd0));
      check($sformatf("v%0d_mimo", i), mimo, vecs[i].exp_mimo);
      check($sformatf("v%0d_hold", i), radio_hold, vecs[i].exp_hold);
      check($sformatf("v%0d_done", i), done_stb, vecs[i].exp_done);
      check($sformatf("v%0d_busy", i), busy, 1'b0);
      if (vecs[i].code == 2'd1) check($sformatf("v%0d_q_timeout_cycles", i), n, QT);
      if (vecs[i].code == 2'd2) check($sformatf("v%0d_hb_timeout_cycles", i), n, 2 + S + HBT);
      repeat (3) step();
    end

    // Second strobe during SETTLE is dropped; original target completes.
    hb_period = 3; hb_cnt = 0; radio_idle = 1'b1;
    strobe(1'b0);
    repeat (5) step();
    strobe(1'b1);
    check("drop_pulse", req_dropped, 1'b1);
    step();
    check("drop_pulse_single", req_dropped, 1'b0);
    n = 0; done_cnt = 0;
    while (!done_stb && n < 300) begin step(); n++; end
    check("drop_seq_finished", 32'(n < 300), 32'd1);
    repeat (5) begin
      if (done_stb) done_cnt++;
      step();
    end
    check("drop_single_done", done_cnt, 1);
    check("drop_target_kept", mimo, 1'b0);
    check("drop_hold_released", radio_hold, 1'b0);

    // Reset while in HBCHECK with mimo already switched.
    strobe(1'b1);
    repeat (S + 4) step();
    check("hbcheck_busy", busy, 1'b1);
    check("hbcheck_mimo", mimo, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_mid_mimo", mimo, 1'b0);
    check("reset_mid_hold", radio_hold, 1'b0);
    check("reset_mid_busy", busy, 1'b0);
    check("reset_mid_error", error, 1'b0);
    step();

    // Randomized traffic against the model.
    for (int seg = 0; seg < 8; seg++) begin
      hb_period = $urandom_range(0, 4);
      case ($urandom_range(0, 3))
        0: idle_pct = 0;
        1: idle_pct = 3;
        2: idle_pct = 30;
        default: idle_pct = 100;
      endcase
      for (int c = 0; c < 200; c++) begin
        mode_req_stb  = ($urandom_range(0, 15) == 0);
        mode_req_mimo = 1'($urandom_range(0, 1));
        radio_idle    = ($urandom_range(0, 99) < idle_pct);
        reset         = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    mode_req_stb = 1'b0;
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
